seq_addsub: RTL and testbench
=============================

# seq_addsub

Parametrised multi-cycle adder/subtractor for the CPU datapath. It generalises the 32-bit combinational adder to any `WIDTH`, adds a subtract mode and carry/overflow/zero flags, and computes the result `CHUNK` bits per clock through a start/ready/done handshake. This trades latency for a short carry chain. The block sits beside the ALU and is used wherever a wide add must not set the critical path.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 8: bits added per cycle. `NCHUNK = WIDTH/CHUNK` is derived and must be ≥ 1.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request. Sampled only when `ready` = 1.
- `sub` input, 1 bit: 0 computes `a + b`; 1 computes `a - b`. Sampled with `start`.
- `a` input, `WIDTH` bits: operand A. Sampled with `start`.
- `b` input, `WIDTH` bits: operand B. Sampled with `start`.
- `ready` output, 1 bit: block idle and can accept `start`.
- `done` output, 1 bit: one-cycle pulse when the result registers update.
- `sum` output, `WIDTH` bits: result, modulo 2^`WIDTH`.
- `carry` output, 1 bit: carry out of the MSB. For subtract this is NOT borrow.
- `overflow` output, 1 bit: two's-complement signed overflow.
- `zero` output, 1 bit: `sum` == 0.

## Operation
- States:
  - IDLE: `ready` = 1.
  - RUN: `ready` = 0, chunk index `idx` runs 0..`NCHUNK`-1.
- IDLE → RUN when `start` & `ready` at an edge (E0). On that edge:
  - latch `a`;
  - latch `b'` = `sub` ? ~`b` : `b`;
  - set `cin` = `sub`;
  - set `idx` = 0.
- RUN, each edge:
  - add chunk `idx` of `a` and `b'` with the running carry;
  - write the `CHUNK`-bit result into the working register at `[idx*CHUNK +: CHUNK]`;
  - store the chunk carry-out as the next carry-in;
  - increment `idx`.
- When `idx` = `NCHUNK`-1, on that edge:
  - load `sum` from the working register, including the final chunk;
  - load `carry` with the final carry;
  - load `overflow` = (`a`[MSB] == `b'`[MSB]) & (`sum`[MSB] != `a`[MSB]);
  - load `zero`;
  - set `done` = 1;
  - return to IDLE.
- Result outputs are registered. They hold the last completed result until the next completion and do not change during RUN.
- `start` while `ready` = 0 is ignored. No queueing. Input changes during RUN have no effect.
- `done` is high for exactly one cycle per accepted request.

## Timing
- Accept at edge E0. Result and `done` update at edge E`NCHUNK`. `done` is high during the cycle after E`NCHUNK`.
- `ready` = (state == IDLE), combinational from state. It rises in the same cycle `done` is high, so a back-to-back `start` is accepted at edge E`NCHUNK`+1. Throughput is one op per `NCHUNK`+1 cycles.
- `CHUNK` == `WIDTH`: latency 1 cycle. The same rules apply.
- Reset values:
  - state IDLE, `idx` = 0, working register and latched operands 0;
  - `sum` = 0, `carry` = 0, `overflow` = 0, `zero` = 0, `done` = 0;
  - `ready` = 1.
- `rst` mid-RUN: the operation aborts immediately (asynchronous) and all outputs take reset values. No `done` is issued for the aborted operation.
- `rst` and `start` together: reset wins. The first accept can occur at the first edge after `rst` deasserts.

## Structure
- Shared package `addsub_pkg`: state enum (IDLE, RUN), and a parameter-check function asserting `WIDTH % CHUNK` == 0.
- Sub-module `addsub_chunk`: combinational `CHUNK`-bit full adder. Inputs: `x`, `y`, `ci`. Outputs: `s`, `co`. Instantiated once, with its operands muxed by `idx`.
- Top level holds the FSM, `idx` counter, operand/working registers, flag logic and handshake.

## Test plan
- Default params. `a`=FFFFFFFF, `b`=00000007, `sub`=0 → `done` 4 edges after accept. `sum`=00000006, `carry`=1, `overflow`=0, `zero`=0.
- `a`=7FFFFFFF, `b`=00000001, `sub`=0 → `sum`=80000000, `overflow`=1, `carry`=0.
- `sub`=1:
  - `a`=5, `b`=5 → `sum`=0, `zero`=1, `carry`=1, `overflow`=0;
  - `a`=0, `b`=1 → `sum`=FFFFFFFF, `carry`=0.
  - `a`=80000000, `b`=1 → `sum`=7FFFFFFF, `overflow`=1.
- `start` held high for 12 cycles with new operands each cycle → accepts only at the E0 / E5 / E10 edges. Exactly one `done` per op. `sum` stable between `done` pulses.
- `rst` pulsed asynchronously during chunk 2 → outputs read 0 and `ready`=1 before the next edge, with no `done`. A following op `a`=3, `b`=4 → `sum`=7.
- Instance `WIDTH`=16, `CHUNK`=16: `a`=FFFF, `b`=0001 → `done` 1 edge after accept, `sum`=0000, `carry`=1, `zero`=1.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared types and elaboration-time helpers for the multi-cycle adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// Combinational CHUNK-bit full adder slice used once per cycle by seq_addsub.
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock behind a
// start/ready/done handshake, with registered sum and carry/overflow/zero flags.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q, zero_q, done_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] x_w, y_w, s_w;
  logic             co_w;

  always_comb begin
    base   = 32'(idx_q) * CHUNK;
    x_w    = a_q[base +: CHUNK];
    y_w    = b_q[base +: CHUNK];
    work_d = work_q;
    work_d[base +: CHUNK] = s_w;
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (x_w),
    .y  (y_w),
    .ci (cin_q),
    .s  (s_w),
    .co (co_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B once here, seed the chain with 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            cin_q   <= sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          cin_q  <= co_w;
          idx_q  <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            sum_q   <= work_d;
            carry_q <= co_w;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_q  <= (work_d == '0);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: default 32/8 instance plus a 16/16 single-cycle instance.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done, carry, overflow, zero;
  logic [31:0] sum;

  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, done16, carry16, ovf16, zero16;
  logic [15:0] sum16;

  seq_addsub dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .carry(carry),
    .overflow(overflow), .zero(zero)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .ready(ready16), .done(done16), .sum(sum16), .carry(carry16),
    .overflow(ovf16), .zero(zero16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t        q32[$], q16[$];
  exp_t        e32, e16;
  logic [31:0] last32 = '0, last16 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst) last32 = '0;
    else if (done) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32: unexpected done, sum %h", sum);
      end else begin
        e32 = q32.pop_front();
        check("lat32", 32'(cyc), 32'(e32.cyc));
        check("sum32", sum, e32.sum);
        check("carry32", {31'b0, carry}, {31'b0, e32.c});
        check("ovf32", {31'b0, overflow}, {31'b0, e32.o});
        check("zero32", {31'b0, zero}, {31'b0, e32.z});
      end
      last32 = sum;
    end else check("hold32", sum, last32);
  end

  always @(negedge clk) begin
    if (rst) last16 = '0;
    else if (done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16: unexpected done, sum %h", sum16);
      end else begin
        e16 = q16.pop_front();
        check("lat16", 32'(cyc), 32'(e16.cyc));
        check("sum16", {16'h0, sum16}, e16.sum);
        check("carry16", {31'b0, carry16}, {31'b0, e16.c});
        check("ovf16", {31'b0, ovf16}, {31'b0, e16.o});
        check("zero16", {31'b0, zero16}, {31'b0, e16.z});
      end
      last16 = {16'h0, sum16};
    end else check("hold16", {16'h0, sum16}, last16);
  end

  task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] es, input logic ec, input logic eo,
                      input logic ez, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) begin timeout("ready32"); return; end
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) q32.push_back('{es, ec, eo, ez, cyc + 4});
  endtask

  task automatic op16(input logic s, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] es, input logic ec, input logic eo,
                      input logic ez);
    int n = 0;
    @(negedge clk);
    while (!ready16 && n < 50) begin @(negedge clk); n++; end
    if (!ready16) begin timeout("ready16"); return; end
    start16 = 1'b1; sub16 = s; a16 = x; b16 = y;
    @(posedge clk); #1;
    start16 = 1'b0;
    q16.push_back('{{16'h0, es}, ec, eo, ez, cyc + 1});
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (q32.size() != 0 || q16.size() != 0) timeout("drain");
    @(negedge clk);
  endtask

  initial begin
    #2;
    check("rst_sum", sum, 32'h0);
    check("rst_flags", {28'b0, carry, overflow, zero, done}, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h1);
    check("rst_ready16", {31'b0, ready16}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    op32(1'b0, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b1);
    op32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    op32(1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    op32(1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op32(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    op32(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1);
    op32(1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // start held high: only the idle cycles (0, 5, 10) accept
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("accept_ready", {31'b0, ready}, (i % 5 == 0) ? 32'h1 : 32'h0);
      start = 1'b1; sub = 1'b0; a = 32'(i); b = 32'd100;
      @(posedge clk); #1;
      if (i % 5 == 0) q32.push_back('{32'(i + 100), 1'b0, 1'b0, 1'b0, cyc + 4});
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    op32(1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_sum", sum, 32'h0);
    check("abort_flags", {28'b0, carry, overflow, zero, done}, 32'h0);
    check("abort_ready", {31'b0, ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    op32(1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    op16(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    op16(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
